// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ADD/SUB/AND/OR/XOR/SLL/SRL and a WIDTH-cycle shift-add MUL.
// The result and its status flags are registered. Only one operation is in flight at a time.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no result held, ready for a new op
// BUSY   | multiply iterating, one multiplier bit per cycle
// DONE   | result/flags held until the consumer takes them
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               is_mul;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;
  logic               alu_v;

  assign in_ready  = ~rst & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign is_mul    = (op == OP_MUL);
  assign out_valid = (state == S_DONE);

  // Single-cycle ops evaluated straight from the inputs; registered on accept.
  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD: begin
        alu_y = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) & (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = sub_w[WIDTH-1:0];
        alu_c = ~sub_w[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) & (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_SLL:  alu_y = a << b[SHW-1:0];
      OP_SRL:  alu_y = a >> b[SHW-1:0];
      default: alu_y = '0;
    endcase
  end

  // One shift-add step: the upper half accumulates, the lower half shifts the multiplier out.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = is_mul ? S_BUSY : S_DONE;
      S_BUSY: if (cnt == '0) state_nxt = S_DONE;
      S_DONE: begin
        if (accept)         state_nxt = is_mul ? S_BUSY : S_DONE;
        else if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result/flag registers and multiplier datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      y      <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        prod  <= {{WIDTH{1'b0}}, b};
        mcand <= a;
        cnt   <= SHW'(WIDTH - 1);
      end else begin
        y      <= alu_y;
        flag_z <= (alu_y == '0);
        flag_n <= alu_y[WIDTH-1];
        flag_c <= alu_c;
        flag_v <= alu_v;
      end
    end else if (state == S_BUSY) begin
      prod <= prod_nxt;
      cnt  <= cnt - 1'b1;
      // Last step: publish the low half; any upper-half bit counts as overflow.
      if (cnt == '0) begin
        y      <= prod_nxt[WIDTH-1:0];
        flag_z <= (prod_nxt[WIDTH-1:0] == '0);
        flag_n <= prod_nxt[WIDTH-1];
        flag_c <= 1'b0;
        flag_v <= |prod_nxt[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule
